// File: rtl/load_store_unit_pkg.sv
// Shared constants for the rv32i memory stage: exception codes, access widths,
// funct3 encodings, LSU FSM states and the funct3 decode helper.
package load_store_unit_pkg;

  localparam int EXCEPTION_LEN = 4;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_OK                = 4'd0;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_READ  = 4'd5;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_WRITE = 4'd7;

  localparam logic [1:0] MEM_WIDTH_BYTE = 2'd0;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'd1;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'd2;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_ISSUE = 2'd1,
    LSU_DONE  = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic       legal;
    logic [1:0] width;
    logic       is_unsigned;
  } lsu_decode_t;

  // Map a funct3 code to access width and sign handling; illegal codes
  // report legal=0 and default to a word access that is never issued.
  function automatic lsu_decode_t decode_funct3(input logic is_read, input logic [2:0] funct3);
    lsu_decode_t d;
    d = '{legal: 1'b0, width: MEM_WIDTH_WORD, is_unsigned: 1'b0};
    if (is_read) begin
      case (funct3)
        FUNCT3_LB:  d = '{legal: 1'b1, width: MEM_WIDTH_BYTE, is_unsigned: 1'b0};
        FUNCT3_LH:  d = '{legal: 1'b1, width: MEM_WIDTH_HALF, is_unsigned: 1'b0};
        FUNCT3_LW:  d = '{legal: 1'b1, width: MEM_WIDTH_WORD, is_unsigned: 1'b0};
        FUNCT3_LBU: d = '{legal: 1'b1, width: MEM_WIDTH_BYTE, is_unsigned: 1'b1};
        FUNCT3_LHU: d = '{legal: 1'b1, width: MEM_WIDTH_HALF, is_unsigned: 1'b1};
        default:    d.legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        FUNCT3_SB: d = '{legal: 1'b1, width: MEM_WIDTH_BYTE, is_unsigned: 1'b0};
        FUNCT3_SH: d = '{legal: 1'b1, width: MEM_WIDTH_HALF, is_unsigned: 1'b0};
        FUNCT3_SW: d = '{legal: 1'b1, width: MEM_WIDTH_WORD, is_unsigned: 1'b0};
        default:   d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

  // Store data is presented right-aligned with the unused upper bytes cleared.
  function automatic logic [31:0] store_mask(input logic [31:0] data, input logic [1:0] width);
    case (width)
      MEM_WIDTH_BYTE: return {24'd0, data[7:0]};
      MEM_WIDTH_HALF: return {16'd0, data[15:0]};
      default:        return data;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bus between the LSU (master) and the data-memory access block (slave).
// Handshake: the master raises memValid_Out and holds every mem*_Out signal
// stable until it sees memOK_In or a non-OK memException_In in the same cycle;
// memException_In is combinational and wins over memOK_In.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic [31:0]              memAddr_Out;
  logic [31:0]              memData_Out;
  logic [1:0]               memWidth_Out;
  logic                     memIsRead_Out;
  logic                     memValid_Out;
  logic [EXCEPTION_LEN-1:0] memException_In;
  logic [31:0]              memData_In;
  logic                     memOK_In;

  modport master (
    output memAddr_Out, memData_Out, memWidth_Out, memIsRead_Out, memValid_Out,
    input  memException_In, memData_In, memOK_In
  );

  modport slave (
    input  memAddr_Out, memData_Out, memWidth_Out, memIsRead_Out, memValid_Out,
    output memException_In, memData_In, memOK_In
  );
endinterface

// File: rtl/load_store_unit_load_data_extend.sv
// Combinational load-data extension: keeps the low byte/half/word of the
// right-aligned read data and sign- or zero-extends it to 32 bits.
module load_data_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  width,
  input  logic        is_unsigned,
  output logic [31:0] value
);

  // Bits above the access width are ignored; the fill bit depends on the sign flag.
  always_comb begin
    value = data;
    case (width)
      MEM_WIDTH_BYTE: value = {{24{data[7]  & ~is_unsigned}}, data[7:0]};
      MEM_WIDTH_HALF: value = {{16{data[15] & ~is_unsigned}}, data[15:0]};
      default:        value = data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage of the rv32i core. Accepts a decoded load/store on
// valid_In && ready_Out, holds one request to the access block until it
// completes or faults, then reports a one-cycle done_Out result.
// Optional build macro LSU_TIMEOUT_EN adds a watchdog (TIMEOUT_CYCLES) on
// the ISSUE wait; without it ISSUE waits indefinitely.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_In,
  output logic                     ready_Out,
  input  logic                     isRead_In,
  input  logic [2:0]               funct3_In,
  input  logic [31:0]              base_In,
  input  logic [31:0]              offset_In,
  input  logic [31:0]              storeData_In,
  input  logic [4:0]               rd_In,
  load_store_unit_if.master        mem,
  output logic                     done_Out,
  output logic [31:0]              result_Out,
  output logic [4:0]               rd_Out,
  output logic                     regWrite_Out,
  output logic [EXCEPTION_LEN-1:0] exception_Out,
  output logic [31:0]              faultAddr_Out,
  output lsu_state_e               state_dbg
);

  lsu_state_e state_q, state_d;

  logic                     accept;
  logic                     finish;
  logic [EXCEPTION_LEN-1:0] finish_exc;
  lsu_decode_t              dec;
  logic [31:0]              addr_sum;
  logic [31:0]              ext_value;

  logic [31:0]              addr_q;
  logic [31:0]              sdata_q;
  logic [1:0]               width_q;
  logic                     uns_q;
  logic                     is_read_q;
  logic [4:0]               rd_q;
  logic [31:0]              result_q;
  logic [4:0]               rd_out_q;
  logic [EXCEPTION_LEN-1:0] exc_q;
  logic [31:0]              fault_q;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q;
`endif

  assign dec      = decode_funct3(isRead_In, funct3_In);
  assign addr_sum = base_In + offset_In;

  load_data_extend u_extend (
    .data        (mem.memData_In),
    .width       (width_q),
    .is_unsigned (uns_q),
    .value       (ext_value)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= LSU_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus the accept/finish strobes that steer the datapath registers.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    finish     = 1'b0;
    finish_exc = EXCEP_OK;
    case (state_q)
      LSU_IDLE: begin
        if (valid_In) begin
          accept  = 1'b1;
          state_d = dec.legal ? LSU_ISSUE : LSU_DONE;
        end
      end
      LSU_ISSUE: begin
        if (mem.memException_In != EXCEP_OK) begin
          finish     = 1'b1;
          finish_exc = mem.memException_In;
          state_d    = LSU_DONE;
        end else if (mem.memOK_In) begin
          finish  = 1'b1;
          state_d = LSU_DONE;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          finish     = 1'b1;
          finish_exc = is_read_q ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE;
          state_d    = LSU_DONE;
        end
`endif
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // Request capture at accept; result, rd and fault info update only on entry to DONE
  // so they hold their last reported values everywhere else.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      sdata_q   <= '0;
      width_q   <= MEM_WIDTH_BYTE;
      uns_q     <= 1'b0;
      is_read_q <= 1'b0;
      rd_q      <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
      exc_q     <= EXCEP_OK;
      fault_q   <= '0;
    end else begin
      if (accept) begin
        addr_q    <= addr_sum;
        sdata_q   <= store_mask(storeData_In, dec.width);
        width_q   <= dec.width;
        uns_q     <= dec.is_unsigned;
        is_read_q <= isRead_In;
        rd_q      <= rd_In;
        if (!dec.legal) begin
          result_q <= '0;
          rd_out_q <= rd_In;
          exc_q    <= isRead_In ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE;
          fault_q  <= addr_sum;
        end
      end
      if (finish) begin
        rd_out_q <= rd_q;
        exc_q    <= finish_exc;
        if (finish_exc == EXCEP_OK) begin
          result_q <= is_read_q ? ext_value : 32'd0;
        end else begin
          result_q <= '0;
          fault_q  <= addr_q;
        end
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  // Watchdog: cleared on entry to ISSUE, counts every cycle spent waiting there.
  always_ff @(posedge clk) begin
    if (rst || accept)             cnt_q <= '0;
    else if (state_q == LSU_ISSUE) cnt_q <= cnt_q + 1'b1;
  end
`endif

  assign ready_Out         = (state_q == LSU_IDLE);
  assign done_Out          = (state_q == LSU_DONE);
  assign mem.memValid_Out  = (state_q == LSU_ISSUE);
  assign mem.memAddr_Out   = addr_q;
  assign mem.memData_Out   = sdata_q;
  assign mem.memWidth_Out  = width_q;
  assign mem.memIsRead_Out = is_read_q;
  assign result_Out        = result_q;
  assign rd_Out            = rd_out_q;
  assign exception_Out     = exc_q;
  assign faultAddr_Out     = fault_q;
  assign regWrite_Out      = done_Out && is_read_q && (exc_q == EXCEP_OK) && (rd_out_q != 5'd0);
  assign state_dbg         = state_q;

endmodule
